// File: rtl/systolic_matmul_ctrl.sv
// Tile-level sequencer for the systolic array: issues the N A/B BRAM fetches,
// drives clk_cnt / matmul_op_in_progress for data setup, and holds the masks for the whole op.
module systolic_matmul_ctrl #(
    parameter int unsigned MAT_MUL_SIZE       = 8,
    parameter int unsigned AWIDTH             = 10,
    parameter int unsigned MASK_WIDTH         = 8,
    parameter int unsigned MEM_ACCESS_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AWIDTH-1:0]     a_base_addr,
    input  logic [AWIDTH-1:0]     b_base_addr,
    input  logic [AWIDTH-1:0]     a_stride,
    input  logic [AWIDTH-1:0]     b_stride,
    input  logic [MASK_WIDTH-1:0] mask_a_rows_in,
    input  logic [MASK_WIDTH-1:0] mask_a_cols_in,
    input  logic [MASK_WIDTH-1:0] mask_b_rows_in,
    input  logic [MASK_WIDTH-1:0] mask_b_cols_in,
    output logic                  busy,
    output logic                  done,
    output logic                  matmul_op_in_progress,
    output logic [7:0]            clk_cnt,
    output logic [AWIDTH-1:0]     a_addr,
    output logic [AWIDTH-1:0]     b_addr,
    output logic                  a_mem_en,
    output logic                  b_mem_en,
    output logic [MASK_WIDTH-1:0] validity_mask_a_rows,
    output logic [MASK_WIDTH-1:0] validity_mask_a_cols,
    output logic [MASK_WIDTH-1:0] validity_mask_b_rows,
    output logic [MASK_WIDTH-1:0] validity_mask_b_cols
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned LAST_CNT = 3 * MAT_MUL_SIZE + MEM_ACCESS_LATENCY - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [AWIDTH-1:0]     a_stride_q, b_stride_q;
    logic [AWIDTH-1:0]     a_stride_nxt, b_stride_nxt;
    logic                  busy_nxt, done_nxt, mop_nxt;
    logic [CNT_W-1:0]      clk_cnt_nxt, cnt_inc;
    logic [AWIDTH-1:0]     a_addr_nxt, b_addr_nxt;
    logic                  a_en_nxt, b_en_nxt;
    logic [MASK_WIDTH-1:0] mar_nxt, mac_nxt, mbr_nxt, mbc_nxt;

    assign cnt_inc = clk_cnt + CNT_W'(1);

    // Next-state and next-output logic; everything holds unless a state says otherwise.
    always_comb begin
        state_nxt    = state;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        mop_nxt      = matmul_op_in_progress;
        clk_cnt_nxt  = clk_cnt;
        a_addr_nxt   = a_addr;
        b_addr_nxt   = b_addr;
        a_en_nxt     = a_mem_en;
        b_en_nxt     = b_mem_en;
        a_stride_nxt = a_stride_q;
        b_stride_nxt = b_stride_q;
        mar_nxt      = validity_mask_a_rows;
        mac_nxt      = validity_mask_a_cols;
        mbr_nxt      = validity_mask_b_rows;
        mbc_nxt      = validity_mask_b_cols;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    busy_nxt     = 1'b1;
                    mop_nxt      = 1'b1;
                    clk_cnt_nxt  = '0;
                    a_addr_nxt   = a_base_addr;
                    b_addr_nxt   = b_base_addr;
                    a_en_nxt     = 1'b1;
                    b_en_nxt     = 1'b1;
                    a_stride_nxt = a_stride;
                    b_stride_nxt = b_stride;
                    mar_nxt      = mask_a_rows_in;
                    mac_nxt      = mask_a_cols_in;
                    mbr_nxt      = mask_b_rows_in;
                    mbc_nxt      = mask_b_cols_in;
                end
            end
            RUN: begin
                if (clk_cnt == CNT_W'(LAST_CNT)) begin
                    state_nxt   = DONE;
                    mop_nxt     = 1'b0;
                    clk_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                    a_en_nxt    = 1'b0;
                    b_en_nxt    = 1'b0;
                end else begin
                    clk_cnt_nxt = cnt_inc;
                    // Fetch window covers clk_cnt 0..N-1; addresses park afterwards.
                    if (cnt_inc < CNT_W'(MAT_MUL_SIZE)) begin
                        a_addr_nxt = a_addr + a_stride_q;
                        b_addr_nxt = b_addr + b_stride_q;
                        a_en_nxt   = 1'b1;
                        b_en_nxt   = 1'b1;
                    end else begin
                        a_en_nxt   = 1'b0;
                        b_en_nxt   = 1'b0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                mop_nxt   = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            matmul_op_in_progress <= 1'b0;
            clk_cnt               <= '0;
            a_addr                <= '0;
            b_addr                <= '0;
            a_mem_en              <= 1'b0;
            b_mem_en              <= 1'b0;
            a_stride_q            <= '0;
            b_stride_q            <= '0;
            validity_mask_a_rows  <= '0;
            validity_mask_a_cols  <= '0;
            validity_mask_b_rows  <= '0;
            validity_mask_b_cols  <= '0;
        end else begin
            state                 <= state_nxt;
            busy                  <= busy_nxt;
            done                  <= done_nxt;
            matmul_op_in_progress <= mop_nxt;
            clk_cnt               <= clk_cnt_nxt;
            a_addr                <= a_addr_nxt;
            b_addr                <= b_addr_nxt;
            a_mem_en              <= a_en_nxt;
            b_mem_en              <= b_en_nxt;
            a_stride_q            <= a_stride_nxt;
            b_stride_q            <= b_stride_nxt;
            validity_mask_a_rows  <= mar_nxt;
            validity_mask_a_cols  <= mac_nxt;
            validity_mask_b_rows  <= mbr_nxt;
            validity_mask_b_cols  <= mbc_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_matmul_ctrl.sv
// Directed bench for systolic_matmul_ctrl: default instance plus a MEM_ACCESS_LATENCY=3 instance.
module tb_systolic_matmul_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned MW = 8;
    localparam int          N  = 8;

    logic          clk, reset, start, start_lat, sel;
    logic [AW-1:0] a_base_addr, b_base_addr, a_stride, b_stride;
    logic [MW-1:0] mask_a_rows_in, mask_a_cols_in, mask_b_rows_in, mask_b_cols_in;

    logic          busy0, done0, mop0, aen0, ben0;
    logic [7:0]    cnt0;
    logic [AW-1:0] aaddr0, baddr0;
    logic [MW-1:0] mar0, mac0, mbr0, mbc0;
    logic          busy1, done1, mop1, aen1, ben1;
    logic [7:0]    cnt1;
    logic [AW-1:0] aaddr1, baddr1;
    logic [MW-1:0] mar1, mac1, mbr1, mbc1;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_matmul_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .a_base_addr(a_base_addr), .b_base_addr(b_base_addr),
        .a_stride(a_stride), .b_stride(b_stride),
        .mask_a_rows_in(mask_a_rows_in), .mask_a_cols_in(mask_a_cols_in),
        .mask_b_rows_in(mask_b_rows_in), .mask_b_cols_in(mask_b_cols_in),
        .busy(busy0), .done(done0), .matmul_op_in_progress(mop0), .clk_cnt(cnt0),
        .a_addr(aaddr0), .b_addr(baddr0), .a_mem_en(aen0), .b_mem_en(ben0),
        .validity_mask_a_rows(mar0), .validity_mask_a_cols(mac0),
        .validity_mask_b_rows(mbr0), .validity_mask_b_cols(mbc0)
    );

    systolic_matmul_ctrl #(.MEM_ACCESS_LATENCY(3)) dut_lat (
        .clk(clk), .reset(reset), .start(start_lat),
        .a_base_addr(a_base_addr), .b_base_addr(b_base_addr),
        .a_stride(a_stride), .b_stride(b_stride),
        .mask_a_rows_in(mask_a_rows_in), .mask_a_cols_in(mask_a_cols_in),
        .mask_b_rows_in(mask_b_rows_in), .mask_b_cols_in(mask_b_cols_in),
        .busy(busy1), .done(done1), .matmul_op_in_progress(mop1), .clk_cnt(cnt1),
        .a_addr(aaddr1), .b_addr(baddr1), .a_mem_en(aen1), .b_mem_en(ben1),
        .validity_mask_a_rows(mar1), .validity_mask_a_cols(mac1),
        .validity_mask_b_rows(mbr1), .validity_mask_b_cols(mbc1)
    );

    // Observation mux so one checking routine covers either instance.
    logic          o_busy, o_done, o_mop, o_aen, o_ben;
    logic [7:0]    o_cnt;
    logic [AW-1:0] o_aaddr, o_baddr;
    logic [MW-1:0] o_mar, o_mac, o_mbr, o_mbc;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;
    assign o_mop   = sel ? mop1   : mop0;
    assign o_aen   = sel ? aen1   : aen0;
    assign o_ben   = sel ? ben1   : ben0;
    assign o_cnt   = sel ? cnt1   : cnt0;
    assign o_aaddr = sel ? aaddr1 : aaddr0;
    assign o_baddr = sel ? baddr1 : baddr0;
    assign o_mar   = sel ? mar1   : mar0;
    assign o_mac   = sel ? mac1   : mac0;
    assign o_mbr   = sel ? mbr1   : mbr0;
    assign o_mbc   = sel ? mbc1   : mbc0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " busy"},    32'(o_busy),  32'd0);
        check({nm, " done"},    32'(o_done),  32'd0);
        check({nm, " mop"},     32'(o_mop),   32'd0);
        check({nm, " clk_cnt"}, 32'(o_cnt),   32'd0);
        check({nm, " a_addr"},  32'(o_aaddr), 32'd0);
        check({nm, " b_addr"},  32'(o_baddr), 32'd0);
        check({nm, " a_en"},    32'(o_aen),   32'd0);
        check({nm, " b_en"},    32'(o_ben),   32'd0);
        check({nm, " mask_ar"}, 32'(o_mar),   32'd0);
        check({nm, " mask_ac"}, 32'(o_mac),   32'd0);
        check({nm, " mask_br"}, 32'(o_mbr),   32'd0);
        check({nm, " mask_bc"}, 32'(o_mbc),   32'd0);
    endtask

    task automatic pulse_start();
        if (sel) start_lat = 1'b1;
        else     start     = 1'b1;
        tick();
        start     = 1'b0;
        start_lat = 1'b0;
    endtask

    // Full operation: cycle k counts from the first RUN cycle (k=1 <=> clk_cnt=0).
    task automatic run_op(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                          input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                          input logic [MW-1:0] mar, input logic [MW-1:0] mac,
                          input logic [MW-1:0] mbr, input logic [MW-1:0] mbc,
                          input int last, input bit inject, input string nm);
        int  fi;
        bit  e_run, e_done, e_busy, e_en;
        string t;
        a_base_addr = ab; b_base_addr = bb; a_stride = sa; b_stride = sb;
        mask_a_rows_in = mar; mask_a_cols_in = mac;
        mask_b_rows_in = mbr; mask_b_cols_in = mbc;
        pulse_start();
        mask_a_rows_in = 8'hFF; mask_a_cols_in = 8'hFF;
        mask_b_rows_in = 8'hFF; mask_b_cols_in = 8'hFF;
        for (int k = 1; k <= last + 4; k++) begin
            fi     = (k - 1 < N) ? k - 1 : N - 1;
            e_run  = (k <= last + 1);
            e_done = (k == last + 2);
            e_busy = (k <= last + 2);
            e_en   = e_run && (k - 1 < N);
            t = $sformatf("%s k=%0d", nm, k);
            check({t, " busy"},    32'(o_busy),  32'(e_busy));
            check({t, " done"},    32'(o_done),  32'(e_done));
            check({t, " mop"},     32'(o_mop),   32'(e_run));
            check({t, " clk_cnt"}, 32'(o_cnt),   e_run ? 32'(k - 1) : 32'd0);
            check({t, " a_addr"},  32'(o_aaddr), 32'(AW'(ab + sa * fi)));
            check({t, " b_addr"},  32'(o_baddr), 32'(AW'(bb + sb * fi)));
            check({t, " a_en"},    32'(o_aen),   32'(e_en));
            check({t, " b_en"},    32'(o_ben),   32'(e_en));
            check({t, " mask_ar"}, 32'(o_mar),   32'(mar));
            check({t, " mask_ac"}, 32'(o_mac),   32'(mac));
            check({t, " mask_br"}, 32'(o_mbr),   32'(mbr));
            check({t, " mask_bc"}, 32'(o_mbc),   32'(mbc));
            // Restart attempts mid-run (clk_cnt=5) and in the DONE cycle.
            if (inject && (k == 6 || k == last + 2)) begin
                if (sel) start_lat = 1'b1;
                else     start     = 1'b1;
            end else begin
                start     = 1'b0;
                start_lat = 1'b0;
            end
            tick();
        end
        start     = 1'b0;
        start_lat = 1'b0;
    endtask

    logic [AW-1:0] wrap_tbl [8];

    initial begin
        wrap_tbl = '{10'h3FC, 10'h3FE, 10'h000, 10'h002, 10'h004, 10'h006, 10'h008, 10'h00A};
        reset = 1'b1; start = 1'b0; start_lat = 1'b0; sel = 1'b0;
        a_base_addr = '0; b_base_addr = '0; a_stride = '0; b_stride = '0;
        mask_a_rows_in = '0; mask_a_cols_in = '0; mask_b_rows_in = '0; mask_b_cols_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset");
        sel = 1'b1; #1;
        check_all_zero("reset_lat");
        sel = 1'b0; #1;

        run_op(10'h010, 10'h200, 10'd1, 10'd1, 8'h01, 8'h7F, 8'hAA, 8'h55, 23, 1'b0, "basic");

        run_op(10'h3FC, 10'h3F0, 10'd2, 10'd5, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 23, 1'b0, "wrap");

        a_base_addr = 10'h3FC; a_stride = 10'd2; b_base_addr = 10'h000; b_stride = 10'd1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_tbl i=%0d a_addr", i), 32'(o_aaddr), 32'(wrap_tbl[i]));
            tick();
        end
        repeat (20) tick();
        check("wrap_tbl idle busy", 32'(o_busy), 32'd0);

        run_op(10'h040, 10'h080, 10'd4, 10'd8, 8'h11, 8'h22, 8'h33, 8'h44, 23, 1'b1, "restart");

        a_base_addr = 10'h020; b_base_addr = 10'h120; a_stride = 10'd1; b_stride = 10'd1;
        mask_a_rows_in = 8'h5A; mask_a_cols_in = 8'h5A; mask_b_rows_in = 8'h5A; mask_b_cols_in = 8'h5A;
        pulse_start();
        repeat (10) tick();
        check("midrst clk_cnt", 32'(o_cnt), 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midrst");
        for (int i = 0; i < 30; i++) begin
            check($sformatf("midrst idle i=%0d done", i), 32'(o_done), 32'd0);
            tick();
        end
        check("midrst idle busy", 32'(o_busy), 32'd0);
        run_op(10'h020, 10'h120, 10'd1, 10'd1, 8'h03, 8'h07, 8'h0F, 8'h1F, 23, 1'b0, "post_rst");

        sel = 1'b1; #1;
        run_op(10'h100, 10'h300, 10'd3, 10'd1, 8'h81, 8'h42, 8'h24, 8'h18, 25, 1'b0, "lat3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_ctrl.md
Name: systolic_matmul_ctrl

Overview:
Sequencer for one tile-level matrix multiply on the MAT_MUL_SIZE x MAT_MUL_SIZE systolic array. It accepts a start request with the tile configuration and generates the BRAM A/B read addresses and enables. It also produces the clk_cnt and matmul_op_in_progress signals that drive the systolic data setup stage, and latches the four validity masks for the whole operation. Completion is signalled with a one-cycle done pulse; the block sits between the instruction/vector control path and the systolic data setup + PE array.

Parameters:
MAT_MUL_SIZE, 8, array dimension N; legal range 2..8.
AWIDTH, 10, BRAM address width.
MASK_WIDTH, 8, validity mask width; must be >= MAT_MUL_SIZE.
MEM_ACCESS_LATENCY, 1, BRAM read latency in cycles; legal range 1..4.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
a_base_addr  in  AWIDTH  first A address
b_base_addr  in  AWIDTH  first B address
a_stride  in  AWIDTH  A address increment per fetch
b_stride  in  AWIDTH  B address increment per fetch
mask_a_rows_in, mask_a_cols_in, mask_b_rows_in, mask_b_cols_in  in  MASK_WIDTH each  validity masks, latched on accepted start
busy  out  1  high from the cycle after accept through the DONE cycle
done  out  1  one-cycle completion pulse
matmul_op_in_progress  out  1  high exactly in RUN
clk_cnt  out  8  cycle counter for data setup
a_addr  out  AWIDTH  BRAM A read address
b_addr  out  AWIDTH  BRAM B read address
a_mem_en  out  1  BRAM A read enable
b_mem_en  out  1  BRAM B read enable
validity_mask_a_rows, validity_mask_a_cols, validity_mask_b_rows, validity_mask_b_cols  out  MASK_WIDTH each  latched masks

Behaviour:
- All outputs are registered. Clock port is clk; reset port is reset; reset is synchronous and active-high.
- Reset values: state = IDLE; every output = 0, including all addresses, enables, masks and clk_cnt.
- Derived constant LAST_CNT = 3*MAT_MUL_SIZE + MEM_ACCESS_LATENCY - 2. With defaults this is 23.
- States: IDLE, RUN, DONE.
- IDLE, start = 1: in the next cycle enter RUN with the following register values.
  - clk_cnt = 0.
  - a_addr = a_base_addr; b_addr = b_base_addr.
  - a_mem_en = b_mem_en = 1.
  - Internal copies of both strides are captured.
  - The four masks are captured into the validity_mask_* outputs.
- IDLE, start = 0: all outputs hold their previous values except done = 0. Addresses and masks keep their last values.
- RUN, every cycle:
  - clk_cnt increments by 1.
  - While the next clk_cnt < MAT_MUL_SIZE: a_addr += a_stride, b_addr += b_stride, enables stay 1. Address arithmetic is modulo 2^AWIDTH and wraps silently.
  - Otherwise: addresses hold and enables go to 0.
  - Exactly MAT_MUL_SIZE enabled fetches occur, at clk_cnt = 0..N-1.
- RUN, when clk_cnt == LAST_CNT: next state is DONE.
  - matmul_op_in_progress drops to 0 and clk_cnt returns to 0.
  - done = 1 for that single cycle; busy stays 1.
- DONE: next state is IDLE unconditionally. busy = 0 and done = 0 in the next cycle.
- start is ignored while in RUN or DONE; it is not queued.
- A start that is high in the same cycle the block returns to IDLE is ignored. Only start seen in the IDLE state is accepted.
- Minimum start-to-start spacing is LAST_CNT + 3 cycles.
- Masks are stable for the entire RUN. Input mask changes during RUN have no effect.
- Reset asserted mid-RUN or in DONE: next cycle state = IDLE and all outputs are at reset values. No done pulse is produced.
- clk_cnt never exceeds LAST_CNT, which is at most 26, so it fits in 8 bits.

Test Plan:
- Basic run: defaults; a_base = 0x010, b_base = 0x200, strides = 1, start at cycle 0 -> cycles 1..8 show a_addr 0x010..0x017 and b_addr 0x200..0x207 with enables high. Enables are low from clk_cnt = 8. matmul_op_in_progress is high for 24 cycles (clk_cnt 0..23), done pulses once at cycle 25, busy is low at cycle 26.
- Stride and wrap: AWIDTH = 10, a_base = 0x3FC, a_stride = 2 -> a_addr sequence 0x3FC, 0x3FE, 0x000, 0x002, ..., 0x00A.
- Start while busy: start pulses again at clk_cnt = 5 and in the DONE cycle -> no restart, exactly one done pulse, and the address sequence is unchanged.
- Mask latch: start with mask_a_cols_in = 0x7F, then drive 0xFF from the next cycle on -> validity_mask_a_cols reads 0x7F throughout RUN.
- Reset mid-op: assert reset at clk_cnt = 10 -> next cycle all outputs are 0 and state is IDLE; done never pulses. A new start afterwards produces a normal 24-cycle run.
- Latency parameter: MEM_ACCESS_LATENCY = 3 -> LAST_CNT = 25, matmul_op_in_progress is high for 26 cycles, and done follows clk_cnt = 25.
